// File: rtl/latch_bank_wr_ctrl.sv
// latch_bank_wr_ctrl: arbitrated setup/open/hold write sequencer for a bank of transparent latches
// Build option LATCH_WR_FIXED_PRIO_EN replaces round-robin with fixed lowest-index priority.
module latch_bank_wr_ctrl #(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = 8,
   parameter  int DEPTH   = 8,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] data_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic [NUM_REQ-1:0]        done_o,
   output logic                      err_o,
   output logic                      busy_o,
   output logic [DEPTH-1:0]          le_o,
   output logic [DATA_W-1:0]         wdata_o
);
   localparam int IDX_W = $clog2(NUM_REQ);
   typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_t;
   state_t              r_state, w_state_nxt;
   logic [IDX_W-1:0]    r_win, w_win, w_win_nxt;
   logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
   logic [NUM_REQ-1:0]  r_gnt, r_done, w_gnt_nxt, w_done_nxt;
   logic                r_err, r_busy, w_err_nxt, w_busy_nxt, w_in_range;
   logic [DEPTH-1:0]    r_le, w_le_nxt;
   logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
`ifndef LATCH_WR_FIXED_PRIO_EN
   logic [IDX_W-1:0]    r_rr;
   logic                w_hit;
   int                  w_idx;
`endif
   assign w_in_range = int'(r_addr) < DEPTH;
   always_comb begin
      w_win = '0;
`ifdef LATCH_WR_FIXED_PRIO_EN
      for (int k = NUM_REQ - 1; k >= 0; k--)
         if (req_i[IDX_W'(k)]) w_win = IDX_W'(k);
`else
      w_hit = 1'b0;
      w_idx = 0;
      // scan from the round-robin pointer, wrapping past the last requester
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = int'(r_rr) + k;
         if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
         if (!w_hit && req_i[IDX_W'(w_idx)]) begin
            w_hit = 1'b1;
            w_win = IDX_W'(w_idx);
         end
      end
`endif
   end
   always_comb begin
      w_state_nxt = r_state;
      w_win_nxt   = r_win;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_gnt_nxt   = '0;
      w_done_nxt  = '0;
      w_err_nxt   = 1'b0;
      w_le_nxt    = '0;
      w_busy_nxt  = 1'b1;
      case (r_state)
         IDLE: begin
            w_busy_nxt = |req_i;
            if (|req_i) begin
               w_state_nxt = SETUP;
               w_win_nxt   = w_win;
               w_addr_nxt  = addr_i[int'(w_win)*ADDR_W +: ADDR_W];
               w_wdata_nxt = data_i[int'(w_win)*DATA_W +: DATA_W];
               w_gnt_nxt   = NUM_REQ'(1) << w_win;
            end
         end
         SETUP: begin
            w_state_nxt = OPEN;
            w_le_nxt    = w_in_range ? DEPTH'(1) << r_addr : '0;
         end
         OPEN: begin
            w_state_nxt = HOLD;
            w_done_nxt  = NUM_REQ'(1) << r_win;
            w_err_nxt   = !w_in_range;
         end
         default: begin
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_win   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_gnt   <= '0;
         r_done  <= '0;
         r_err   <= 1'b0;
         r_le    <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_win   <= w_win_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
         r_gnt   <= w_gnt_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         r_le    <= w_le_nxt;
         r_busy  <= w_busy_nxt;
      end
   end
`ifndef LATCH_WR_FIXED_PRIO_EN
   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_rr <= '0;
      else if (r_state == HOLD) r_rr <= (int'(r_win) == NUM_REQ - 1) ? '0 : r_win + 1'b1;
   end
`endif
   assign gnt_o   = r_gnt;
   assign done_o  = r_done;
   assign err_o   = r_err;
   assign busy_o  = r_busy;
   assign le_o    = r_le;
   assign wdata_o = r_wdata;
endmodule
